// File: rtl/rt_ibex_window_pkg.sv
// Shared types and frame layout for the register-window spill/fill controller.
// The EABI index table is also used by the regfile's offset decode.
package rt_ibex_window_pkg;

    localparam int unsigned FrameWords = 9;
    localparam int unsigned FrameBytes = 36;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACK,
        S_SPILL_REQ,
        S_SPILL_WAIT,
        S_SPILL_DONE,
        S_FILL_REQ,
        S_FILL_WAIT,
        S_FILL_DONE
    } spill_state_e;

    typedef enum logic [2:0] {
        ACK_PUSH,
        ACK_POP,
        ACK_OVF,
        ACK_ERR_PUSH,
        ACK_ERR_POP,
        ACK_ERR_BOTH
    } ack_kind_e;

    // Frame slots 0..6 hold x1, x5, x10, x11, x12, x13, x15 (entry 0 is the LSB slice).
    localparam logic [6:0][4:0] EabiTable = {
        5'd15, 5'd13, 5'd12, 5'd11, 5'd10, 5'd5, 5'd1
    };

    function automatic logic [4:0] eabi_idx_to_addr(input logic [3:0] idx);
        logic [4:0] a;
        a = 5'd0;
        if (idx < 4'd7) begin
            a = EabiTable[idx[2:0]];
        end
        return a;
    endfunction

endpackage

// File: rtl/rt_ibex_window_spill_ctrl.sv
// Register-window push/pop controller: spills the top window to a descending
// memory stack on interrupt entry when the regfile is full, and fills it back on mret.
module rt_ibex_window_spill_ctrl
    import rt_ibex_window_pkg::*;
#(
    parameter int unsigned NumRegisterWindows = 4,
    parameter int unsigned MaxSpillDepth      = 8,
    parameter logic [31:0] SpillBase          = 32'h0001_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        push_req_i,
    input  logic        pop_req_i,
    output logic        push_ack_o,
    output logic        pop_ack_o,
    output logic        busy_o,
    input  logic        window_full_i,
    output logic        increment_ptr_o,
    output logic        decrement_ptr_o,
    output logic        save_csr_o,
    input  logic [31:0] mcause_i,
    input  logic [31:0] mepc_i,
    output logic [4:0]  rf_raddr_o,
    input  logic [31:0] rf_rdata_i,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o,
    output logic        rf_we_o,
    output logic        csr_restore_o,
    output logic [31:0] mcause_o,
    output logic [31:0] mepc_o,
    output logic        data_req_o,
    output logic        data_we_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic        data_err_i,
    input  logic [31:0] data_rdata_i,
    output logic        overflow_o,
    output logic        err_o
);

    localparam int unsigned DepthW = $clog2(MaxSpillDepth + 1);
    localparam logic [DepthW-1:0] DepthMax = DepthW'(MaxSpillDepth);
    localparam logic [3:0] LastIdx = 4'(FrameWords - 1);

    if (NumRegisterWindows < 2) begin : g_bad_windows
        $error("NumRegisterWindows must be at least 2");
    end

    spill_state_e      r_state, w_state_nx;
    ack_kind_e         r_kind, w_kind_nx;
    logic [3:0]        r_idx, w_idx_nx;
    logic [31:0]       r_ptr;
    logic [DepthW-1:0] r_depth;
    logic [31:0]       r_wdata;
    logic              r_hold;
    logic [31:0]       r_mcause;
    logic [31:0]       r_mepc;

    logic        w_spill;
    logic        w_fill_req;
    logic        w_rsp;
    logic        w_fill_rsp;
    logic        w_last;
    logic [4:0]  w_arch;
    logic [31:0] w_src;
    logic [31:0] w_off;
    logic [31:0] w_frame_lo;

    assign w_spill    = (r_state == S_SPILL_REQ);
    assign w_fill_req = (r_state == S_FILL_REQ);
    assign w_rsp      = data_rvalid_i &&
                        ((r_state == S_SPILL_WAIT) || (r_state == S_FILL_WAIT));
    assign w_fill_rsp = data_rvalid_i && !data_err_i && (r_state == S_FILL_WAIT);
    assign w_last     = (r_idx == LastIdx);
    assign w_arch     = eabi_idx_to_addr(r_idx);
    assign w_src      = (r_idx == 4'd7) ? mcause_i :
                        (r_idx == 4'd8) ? mepc_i : rf_rdata_i;
    assign w_off      = {26'd0, r_idx, 2'b00};
    assign w_frame_lo = r_ptr - 32'(FrameBytes);

    always_comb begin
        w_state_nx = r_state;
        w_kind_nx  = r_kind;
        w_idx_nx   = r_idx;
        unique case (r_state)
            S_IDLE: begin
                w_idx_nx = 4'd0;
                if (push_req_i && pop_req_i) begin
                    w_state_nx = S_ACK;
                    w_kind_nx  = ACK_ERR_BOTH;
                end else if (push_req_i) begin
                    if (!window_full_i) begin
                        w_state_nx = S_ACK;
                        w_kind_nx  = ACK_PUSH;
                    end else if (r_depth == DepthMax) begin
                        w_state_nx = S_ACK;
                        w_kind_nx  = ACK_OVF;
                    end else begin
                        w_state_nx = S_SPILL_REQ;
                    end
                end else if (pop_req_i) begin
                    if (r_depth == '0) begin
                        w_state_nx = S_ACK;
                        w_kind_nx  = ACK_POP;
                    end else begin
                        w_state_nx = S_FILL_REQ;
                    end
                end
            end
            S_SPILL_REQ: if (data_gnt_i) w_state_nx = S_SPILL_WAIT;
            S_FILL_REQ:  if (data_gnt_i) w_state_nx = S_FILL_WAIT;
            S_SPILL_WAIT, S_FILL_WAIT: begin
                if (w_rsp) begin
                    if (data_err_i) begin
                        w_state_nx = S_ACK;
                        w_kind_nx  = (r_state == S_SPILL_WAIT) ? ACK_ERR_PUSH
                                                               : ACK_ERR_POP;
                    end else if (w_last) begin
                        w_state_nx = (r_state == S_SPILL_WAIT) ? S_SPILL_DONE
                                                               : S_FILL_DONE;
                    end else begin
                        w_idx_nx   = r_idx + 4'd1;
                        w_state_nx = (r_state == S_SPILL_WAIT) ? S_SPILL_REQ
                                                               : S_FILL_REQ;
                    end
                end
            end
            S_ACK, S_SPILL_DONE, S_FILL_DONE: w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Handshake and regfile strobes are pure functions of the registered state.
    always_comb begin
        push_ack_o      = 1'b0;
        pop_ack_o       = 1'b0;
        increment_ptr_o = 1'b0;
        decrement_ptr_o = 1'b0;
        save_csr_o      = 1'b0;
        csr_restore_o   = 1'b0;
        overflow_o      = 1'b0;
        err_o           = 1'b0;
        unique case (r_state)
            S_ACK: begin
                push_ack_o      = r_kind inside {ACK_PUSH, ACK_OVF, ACK_ERR_PUSH};
                pop_ack_o       = r_kind inside {ACK_POP, ACK_ERR_POP};
                increment_ptr_o = (r_kind == ACK_PUSH);
                save_csr_o      = (r_kind == ACK_PUSH);
                decrement_ptr_o = (r_kind == ACK_POP);
                overflow_o      = (r_kind == ACK_OVF);
                err_o           = r_kind inside {ACK_ERR_PUSH, ACK_ERR_POP,
                                                 ACK_ERR_BOTH};
            end
            S_SPILL_DONE: begin
                save_csr_o = 1'b1;
                push_ack_o = 1'b1;
            end
            S_FILL_DONE: begin
                csr_restore_o = 1'b1;
                pop_ack_o     = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy_o       = !(r_state inside {S_IDLE, S_ACK});
    assign data_req_o   = w_spill || w_fill_req;
    assign data_we_o    = w_spill;
    assign data_addr_o  = w_spill    ? w_frame_lo + w_off :
                          w_fill_req ? r_ptr + w_off : 32'd0;
    // First request cycle forwards the live source; later cycles replay the capture.
    assign data_wdata_o = !w_spill ? 32'd0 : (r_hold ? r_wdata : w_src);
    assign rf_raddr_o   = w_spill ? w_arch : 5'd0;
    assign rf_we_o      = w_fill_rsp && (r_idx < 4'd7);
    assign rf_waddr_o   = rf_we_o ? w_arch : 5'd0;
    assign rf_wdata_o   = rf_we_o ? data_rdata_i : 32'd0;
    assign mcause_o     = r_mcause;
    assign mepc_o       = r_mepc;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= S_IDLE;
            r_kind   <= ACK_PUSH;
            r_idx    <= 4'd0;
            r_ptr    <= SpillBase;
            r_depth  <= '0;
            r_wdata  <= 32'd0;
            r_hold   <= 1'b0;
            r_mcause <= 32'd0;
            r_mepc   <= 32'd0;
        end else begin
            r_state <= w_state_nx;
            r_kind  <= w_kind_nx;
            r_idx   <= w_idx_nx;
            r_hold  <= w_spill && !data_gnt_i;
            if (w_spill && !r_hold) begin
                r_wdata <= w_src;
            end
            if (w_fill_rsp && (r_idx == 4'd7)) begin
                r_mcause <= data_rdata_i;
            end
            if (w_fill_rsp && (r_idx == 4'd8)) begin
                r_mepc <= data_rdata_i;
            end
            if (r_state == S_SPILL_DONE) begin
                r_ptr   <= r_ptr - 32'(FrameBytes);
                r_depth <= r_depth + DepthW'(1);
            end else if (r_state == S_FILL_DONE) begin
                r_ptr   <= r_ptr + 32'(FrameBytes);
                r_depth <= r_depth - DepthW'(1);
            end
        end
    end

endmodule

// File: doc/rt_ibex_window_spill_ctrl.md
Name: rt_ibex_window_spill_ctrl

Overview:
Controller that drives the register-window file's pointer and CSR-save strobes on interrupt entry (push) and mret (pop).
- Push with window_full_i set: spills the top window's 7 EABI registers plus the saved mcause/mepc to a descending memory stack, then reuses the window.
- Pop with spilled frames outstanding: fills that window back from memory instead of decrementing.
- Sits between the ID/controller stage, the register-window file and a dedicated LSU-style data port.

Parameters:
NumRegisterWindows, 4, window count in the regfile (informational; window_full_i is the only fullness source)
MaxSpillDepth, 8, maximum frames held in memory
SpillBase, 32'h0001_0000, initial spill stack pointer (exclusive top, word aligned)

Ports:
clk_i  in  1  clock
rst_ni  in  1  async active-low reset
push_req_i  in  1  interrupt-entry request, held until push_ack_o
pop_req_i  in  1  mret request, held until pop_ack_o
push_ack_o  out  1  one-cycle completion pulse for push
pop_ack_o  out  1  one-cycle completion pulse for pop
busy_o  out  1  spill/fill in progress, core must stall
window_full_i  in  1  regfile top window in use
increment_ptr_o  out  1  one-cycle pulse to regfile
decrement_ptr_o  out  1  one-cycle pulse to regfile
save_csr_o  out  1  one-cycle pulse, regfile latches mcause/mepc
mcause_i, mepc_i  in  32 each  current aux slot contents from regfile
rf_raddr_o  out  5  architectural read address during spill
rf_rdata_i  in  32  combinational read data
rf_waddr_o  out  5  write address during fill
rf_wdata_o  out  32  fill write data
rf_we_o  out  1  fill write strobe
csr_restore_o  out  1  pulse: restored mcause_o/mepc_o valid
mcause_o, mepc_o  out  32 each  restored CSR values
data_req_o, data_we_o  out  1 each  memory request / write
data_addr_o, data_wdata_o  out  32 each  word address / write data
data_gnt_i, data_rvalid_i, data_err_i  in  1 each  grant / response valid / bus error
data_rdata_i  in  32  read data
overflow_o  out  1  pulse: push refused, depth == MaxSpillDepth
err_o  out  1  pulse: bus error or simultaneous push+pop

Behaviour:
- Reset values:
  - all outputs 0; spill_ptr = SpillBase; depth = 0; state IDLE.
  - Reset mid-operation abandons the transfer; memory contents are undefined.
- Frame layout: 9 words, 36 bytes.
  - idx 0..6 = x1, x5, x10, x11, x12, x13, x15; idx 7 = mcause; idx 8 = mepc.
  - Spill word address = spill_ptr - 36 + 4*idx; fill word address = spill_ptr + 4*idx.
- Requests are sampled only in IDLE.
  - push and pop asserted in the same cycle: neither is taken, err_o pulses, no acks.
- Fast push (!window_full_i): IDLE -> ACK. In ACK, increment_ptr_o, save_csr_o and push_ack_o all pulse; next state IDLE. Latency 1 cycle.
- Spill push (window_full_i, depth < Max): IDLE -> SPILL_REQ.
  - SPILL_REQ:
    - rf_raddr_o = arch reg of idx.
    - wdata = rf_rdata_i / mcause_i / mepc_i, registered on entry and held stable until gnt.
    - data_req_o = 1, data_we_o = 1.
  - On gnt -> SPILL_WAIT. On rvalid, idx++; after idx 8 -> SPILL_DONE, else back to SPILL_REQ.
  - SPILL_DONE: spill_ptr -= 36, depth++, save_csr_o and push_ack_o pulse. No increment_ptr_o (regfile saturates).
- Spill push with depth == MaxSpillDepth: overflow_o pulses, push_ack_o pulses, no other side effects.
- Pop with depth == 0: one cycle ACK state; decrement_ptr_o and pop_ack_o pulse.
- Pop with depth > 0: FILL_REQ / FILL_WAIT loop, one outstanding read at a time.
  - idx 0..6 on rvalid: rf_we_o pulses with rf_waddr_o = arch reg, rf_wdata_o = data_rdata_i.
  - idx 7/8: data captured into mcause_o/mepc_o.
  - FILL_DONE: csr_restore_o and pop_ack_o pulse, spill_ptr += 36, depth--. No decrement_ptr_o.
- data_req_o stays asserted until gnt; at most one transaction outstanding.
- busy_o = 1 in every state except IDLE and ACK.
- data_err_i with rvalid:
  - err_o pulses; return to IDLE; ack pulses for the pending request.
  - spill_ptr and depth unchanged; partial frame is discarded (spill) or partially written (fill).
- Arithmetic: spill_ptr is 32-bit modulo. depth width is $clog2(MaxSpillDepth+1).

Decomposition:
- Shared package rt_ibex_window_pkg:
  - spill_state_e enum
  - FrameWords = 9, FrameBytes = 36
  - function eabi_idx_to_addr (idx -> 5-bit arch reg)
  - the EABI index->register table, shared with the regfile's offset decode
- Optional sub-module rt_ibex_spill_lsu_if: single-outstanding req/gnt/rvalid sequencer, reused for both spill and fill.

Test Plan:
- window_full_i=0, push -> increment_ptr_o and save_csr_o pulse, push_ack_o 1 cycle after request, no data_req_o.
- window_full_i=1, regs x1=0x11, x5=0x55, mcause_i=0x8000_0007, immediate gnt/rvalid -> 9 writes to 0xFFDC..0xFFFC with the matching values; spill_ptr=0xFFDC, depth=1, no increment_ptr_o.
- Pop after the prior scenario, memory returns the same data -> 7 rf_we_o pulses restoring x1=0x11 etc.; csr_restore_o with mcause_o=0x8000_0007; spill_ptr back to 0x1_0000, no decrement_ptr_o.
- Fill with gnt delayed 3 cycles and rvalid delayed 2 -> data_req_o and data_addr_o held stable, busy_o high throughout, order preserved.
- depth=8 plus a further push with window_full_i=1 -> overflow_o pulse, no memory traffic; push and pop together in IDLE -> err_o pulse, no acks.
- data_err_i on spill word 4 -> err_o pulse, depth and spill_ptr unchanged; rst_ni low mid-fill -> all outputs 0 and state IDLE.
